// File: rtl/uart_stream_port_if.sv
// Byte-stream handshake bundle between the core and the UART port.
// The master is the core side; the slave is uart_stream_port.
interface uart_stream_port_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;

    modport master (
        output tx_data, tx_valid, rx_ready,
        input  tx_ready, rx_data, rx_valid
    );

    modport slave (
        input  tx_data, tx_valid, rx_ready,
        output tx_ready, rx_data, rx_valid
    );
endinterface

// File: rtl/uart_stream_port.sv
// UART transceiver with TX/RX FIFOs, run-time baud divisor, optional parity
// and sticky error flags.
module uart_stream_port #(
    parameter  int FIFO_DEPTH = 16,
    parameter  int DIV_WIDTH  = 16,
    parameter  int PARITY_EN  = 0,
    parameter  int PARITY_ODD = 0,
    localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic [DIV_WIDTH-1:0] clk_div,
    input  logic                 rxd,
    output logic                 txd,
    uart_stream_port_if.slave    strm,
    output logic [LVL_W-1:0]     tx_level,
    output logic [LVL_W-1:0]     rx_level,
    output logic                 tx_busy,
    output logic                 err_frame,
    output logic                 err_parity,
    output logic                 err_overrun,
    input  logic                 err_clear
);
    localparam int AW = LVL_W - 1;

    function automatic logic [DIV_WIDTH-1:0] sat_div(input logic [DIV_WIDTH-1:0] d);
        return (d < DIV_WIDTH'(4)) ? DIV_WIDTH'(4) : d;
    endfunction

    function automatic logic par_bit(input logic [7:0] d);
        return (^d) ^ (PARITY_ODD != 0);
    endfunction

    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

    // TX FIFO
    logic [7:0]    tx_mem [FIFO_DEPTH];
    logic [AW-1:0] tx_wr, tx_rd;
    logic          tx_full, tx_empty, tx_push, tx_pop;

    assign tx_full       = (tx_level == LVL_W'(FIFO_DEPTH));
    assign tx_empty      = (tx_level == '0);
    assign strm.tx_ready = !tx_full;
    assign tx_push       = strm.tx_valid && !tx_full;

    always_ff @(posedge wb_clk_i) begin
        if (tx_push) tx_mem[tx_wr] <= strm.tx_data;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            tx_wr    <= '0;
            tx_rd    <= '0;
            tx_level <= '0;
        end else begin
            if (tx_push) tx_wr <= tx_wr + AW'(1);
            if (tx_pop)  tx_rd <= tx_rd + AW'(1);
            case ({tx_push, tx_pop})
                2'b10:   tx_level <= tx_level + LVL_W'(1);
                2'b01:   tx_level <= tx_level - LVL_W'(1);
                default: ;
            endcase
        end
    end

    // TX shifter; txd and tx_busy are registered one cycle behind the state
    tx_state_t            tx_state, tx_state_nxt;
    logic [DIV_WIDTH-1:0] tx_div, tx_tick;
    logic [2:0]           tx_bit;
    logic [7:0]           tx_shift;
    logic                 tx_par, tx_line, tx_bit_end;

    assign tx_bit_end = (tx_tick == tx_div - DIV_WIDTH'(1));

    always_comb begin
        tx_state_nxt = tx_state;
        tx_pop       = 1'b0;
        tx_line      = 1'b1;
        case (tx_state)
            TX_IDLE: begin
                if (!tx_empty) begin
                    tx_pop       = 1'b1;
                    tx_state_nxt = TX_START;
                end
            end
            TX_START: begin
                tx_line = 1'b0;
                if (tx_bit_end) tx_state_nxt = TX_DATA;
            end
            TX_DATA: begin
                tx_line = tx_shift[0];
                if (tx_bit_end && tx_bit == 3'd7)
                    tx_state_nxt = (PARITY_EN != 0) ? TX_PARITY : TX_STOP;
            end
            TX_PARITY: begin
                tx_line = tx_par;
                if (tx_bit_end) tx_state_nxt = TX_STOP;
            end
            TX_STOP: begin
                if (tx_bit_end) begin
                    if (!tx_empty) begin
                        tx_pop       = 1'b1;
                        tx_state_nxt = TX_START;
                    end else begin
                        tx_state_nxt = TX_IDLE;
                    end
                end
            end
            default: tx_state_nxt = TX_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            tx_state <= TX_IDLE;
            txd      <= 1'b1;
            tx_busy  <= 1'b0;
            tx_tick  <= '0;
            tx_bit   <= '0;
        end else begin
            tx_state <= tx_state_nxt;
            txd      <= tx_line;
            tx_busy  <= (tx_state != TX_IDLE);
            if (tx_pop) begin
                tx_tick <= '0;
                tx_bit  <= '0;
            end else if (tx_state != TX_IDLE) begin
                if (tx_bit_end) begin
                    tx_tick <= '0;
                    if (tx_state == TX_DATA) tx_bit <= tx_bit + 3'd1;
                end else begin
                    tx_tick <= tx_tick + DIV_WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (tx_pop) begin
            tx_shift <= tx_mem[tx_rd];
            tx_div   <= sat_div(clk_div);
            tx_par   <= par_bit(tx_mem[tx_rd]);
        end else if (tx_state == TX_DATA && tx_bit_end) begin
            tx_shift <= tx_shift >> 1;
        end
    end

    // RX synchroniser; rs is the only view of the line the RX FSM uses
    logic rxd_p0, rxd_p1, rs;

    always_ff @(posedge wb_clk_i) begin
        rxd_p0 <= rxd;
        rxd_p1 <= rxd_p0;
    end
    assign rs = rxd_p1;

    rx_state_t            rx_state, rx_state_nxt;
    logic [DIV_WIDTH-1:0] rx_div, rx_tick, rx_target;
    logic [2:0]           rx_bit;
    logic [7:0]           rx_shift;
    logic                 rx_par, rx_armed, rx_sample, rx_par_ok, rx_start, rx_done;
    logic                 set_frame, set_parity, set_overrun;
    logic [7:0]           rx_mem [FIFO_DEPTH];
    logic [AW-1:0]        rx_wr, rx_rd;
    logic                 rx_full, rx_valid, rx_push, rx_pop;

    // The start bit is resampled half a bit in, which centres every later sample
    assign rx_target = (rx_state == RX_START) ? (rx_div >> 1) : rx_div;
    assign rx_sample = (rx_tick == rx_target - DIV_WIDTH'(1));
    assign rx_par_ok = (PARITY_EN == 0) || (rx_par == par_bit(rx_shift));

    always_comb begin
        rx_state_nxt = rx_state;
        rx_start     = 1'b0;
        rx_done      = 1'b0;
        set_frame    = 1'b0;
        set_parity   = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (rx_armed && !rs) begin
                    rx_start     = 1'b1;
                    rx_state_nxt = RX_START;
                end
            end
            RX_START: begin
                if (rx_sample) rx_state_nxt = rs ? RX_IDLE : RX_DATA;
            end
            RX_DATA: begin
                if (rx_sample && rx_bit == 3'd7)
                    rx_state_nxt = (PARITY_EN != 0) ? RX_PARITY : RX_STOP;
            end
            RX_PARITY: begin
                if (rx_sample) rx_state_nxt = RX_STOP;
            end
            RX_STOP: begin
                if (rx_sample) begin
                    rx_state_nxt = RX_IDLE;
                    if (!rs)             set_frame  = 1'b1;
                    else if (!rx_par_ok) set_parity = 1'b1;
                    else                 rx_done    = 1'b1;
                end
            end
            default: rx_state_nxt = RX_IDLE;
        endcase
    end

    assign rx_full     = (rx_level == LVL_W'(FIFO_DEPTH));
    assign rx_valid    = (rx_level != '0);
    assign rx_pop      = rx_valid && strm.rx_ready;
    assign rx_push     = rx_done && (!rx_full || rx_pop);
    assign set_overrun = rx_done && rx_full && !rx_pop;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            rx_state <= RX_IDLE;
            rx_armed <= 1'b0;
            rx_tick  <= '0;
            rx_bit   <= '0;
        end else begin
            rx_state <= rx_state_nxt;
            if (rx_state != RX_IDLE) rx_armed <= 1'b0;
            else if (rs)             rx_armed <= 1'b1;
            if (rx_start) begin
                rx_tick <= '0;
                rx_bit  <= '0;
            end else if (rx_state != RX_IDLE) begin
                if (rx_sample) begin
                    rx_tick <= '0;
                    if (rx_state == RX_DATA) rx_bit <= rx_bit + 3'd1;
                end else begin
                    rx_tick <= rx_tick + DIV_WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (rx_start) rx_div <= sat_div(clk_div);
        if (rx_state == RX_DATA && rx_sample) rx_shift <= {rs, rx_shift[7:1]};
        if (rx_state == RX_PARITY && rx_sample) rx_par <= rs;
        if (rx_push) rx_mem[rx_wr] <= rx_shift;
    end

    // RX FIFO, first-word fall-through; the head reads as zero when empty
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            rx_wr    <= '0;
            rx_rd    <= '0;
            rx_level <= '0;
        end else begin
            if (rx_push) rx_wr <= rx_wr + AW'(1);
            if (rx_pop)  rx_rd <= rx_rd + AW'(1);
            case ({rx_push, rx_pop})
                2'b10:   rx_level <= rx_level + LVL_W'(1);
                2'b01:   rx_level <= rx_level - LVL_W'(1);
                default: ;
            endcase
        end
    end

    assign strm.rx_valid = rx_valid;
    assign strm.rx_data  = rx_valid ? rx_mem[rx_rd] : 8'h00;

    // An error raised in the same cycle as err_clear wins
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            err_frame   <= 1'b0;
            err_parity  <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            err_frame   <= (err_frame   && !err_clear) || set_frame;
            err_parity  <= (err_parity  && !err_clear) || set_parity;
            err_overrun <= (err_overrun && !err_clear) || set_overrun;
        end
    end
endmodule

// File: tb/tb_uart_stream_port.sv
// Directed bench for uart_stream_port: A = no parity, depth 4; B = odd parity.
module tb_uart_stream_port;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [15:0] div_a, div_b;
    logic        rxd_drv_a, rxd_drv_b, loop_a;
    logic        rxd_a, txd_a, txd_b;
    logic [2:0]  txl_a, rxl_a;
    logic [4:0]  txl_b, rxl_b;
    logic        busy_a, busy_b, clr_a, clr_b;
    logic        ef_a, ep_a, eo_a, ef_b, ep_b, eo_b;

    uart_stream_port_if sa ();
    uart_stream_port_if sb ();

    assign rxd_a = loop_a ? txd_a : rxd_drv_a;

    uart_stream_port #(.FIFO_DEPTH(4), .DIV_WIDTH(16), .PARITY_EN(0), .PARITY_ODD(0)) dut_a (
        .wb_clk_i(clk), .wb_rst_i(rst), .clk_div(div_a), .rxd(rxd_a), .txd(txd_a),
        .strm(sa), .tx_level(txl_a), .rx_level(rxl_a), .tx_busy(busy_a),
        .err_frame(ef_a), .err_parity(ep_a), .err_overrun(eo_a), .err_clear(clr_a)
    );

    uart_stream_port #(.FIFO_DEPTH(16), .DIV_WIDTH(16), .PARITY_EN(1), .PARITY_ODD(1)) dut_b (
        .wb_clk_i(clk), .wb_rst_i(rst), .clk_div(div_b), .rxd(rxd_drv_b), .txd(txd_b),
        .strm(sb), .tx_level(txl_b), .rx_level(rxl_b), .tx_busy(busy_b),
        .err_frame(ef_b), .err_parity(ep_b), .err_overrun(eo_b), .err_clear(clr_b)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
        end
    endtask

    task automatic push(input int which, input logic [7:0] b);
        if (which == 0) begin sa.tx_data = b; sa.tx_valid = 1'b1; end
        else            begin sb.tx_data = b; sb.tx_valid = 1'b1; end
        @(posedge clk); #1;
        sa.tx_valid = 1'b0;
        sb.tx_valid = 1'b0;
    endtask

    // Called right after push(); watches every cycle of the frame on txd.
    task automatic check_tx(input int which, input logic [11:0] bits, input int nbits,
                            input int div, input string tag, output logic [11:0] obs);
        int   errs;
        logic t;
        errs = 0;
        obs  = '0;
        @(negedge clk);
        @(negedge clk);
        chk({tag, "_pre_txd"},  which == 0 ? txd_a : txd_b, 1);
        chk({tag, "_pre_busy"}, which == 0 ? busy_a : busy_b, 0);
        for (int k = 0; k < nbits * div; k++) begin
            @(negedge clk);
            t = (which == 0) ? txd_a : txd_b;
            if (t !== bits[k / div]) errs++;
            if (k % div == div / 2) obs[k / div] = t;
        end
        chk({tag, "_wave_errs"}, errs, 0);
        chk({tag, "_busy_last"}, which == 0 ? busy_a : busy_b, 1);
        @(negedge clk);
        chk({tag, "_post_busy"}, which == 0 ? busy_a : busy_b, 0);
        chk({tag, "_post_txd"},  which == 0 ? txd_a : txd_b, 1);
    endtask

    task automatic drive(input int which, input logic [11:0] bits, input int nbits, input int div);
        @(posedge clk); #1;
        for (int i = 0; i < nbits; i++) begin
            if (which == 0) rxd_drv_a = bits[i];
            else            rxd_drv_b = bits[i];
            repeat (div) @(posedge clk);
            #1;
        end
        rxd_drv_a = 1'b1;
        rxd_drv_b = 1'b1;
    endtask

    task automatic pop_chk(input int which, input logic [7:0] exp, input string tag);
        @(negedge clk);
        chk({tag, "_valid"}, which == 0 ? sa.rx_valid : sb.rx_valid, 1);
        chk({tag, "_data"},  which == 0 ? sa.rx_data  : sb.rx_data,  exp);
        if (which == 0) sa.rx_ready = 1'b1; else sb.rx_ready = 1'b1;
        @(posedge clk); #1;
        sa.rx_ready = 1'b0;
        sb.rx_ready = 1'b0;
    endtask

    task automatic clear_a();
        @(negedge clk);
        clr_a = 1'b1;
        @(posedge clk); #1;
        clr_a = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [11:0] obs;
        int          lows;

        rst = 1'b1;
        div_a = 16'd8; div_b = 16'd8;
        rxd_drv_a = 1'b1; rxd_drv_b = 1'b1; loop_a = 1'b0;
        clr_a = 1'b0; clr_b = 1'b0;
        sa.tx_data = 8'h00; sa.tx_valid = 1'b0; sa.rx_ready = 1'b0;
        sb.tx_data = 8'h00; sb.tx_valid = 1'b0; sb.rx_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        chk("rst_txd",      txd_a, 1);
        chk("rst_tx_ready", sa.tx_ready, 1);
        chk("rst_busy",     busy_a, 0);
        chk("rst_rx_valid", sa.rx_valid, 0);
        chk("rst_rx_data",  sa.rx_data, 8'h00);
        chk("rst_levels",   {txl_a, rxl_a}, 6'd0);
        chk("rst_errs",     {ef_a, ep_a, eo_a}, 3'b000);
        chk("rst_txd_b",    txd_b, 1);

        // TX waveform: 0xA5 at divisor 8
        push(0, 8'hA5);
        check_tx(0, {2'b00, 1'b1, 8'hA5, 1'b0}, 10, 8, "txA5", obs);

        // Loopback at an odd divisor
        loop_a = 1'b1;
        div_a  = 16'd5;
        repeat (2) @(negedge clk);
        push(0, 8'h00);
        push(0, 8'hFF);
        push(0, 8'h3C);
        for (int i = 0; i < 600 && rxl_a != 3'd3; i++) @(negedge clk);
        chk("loop_level", rxl_a, 3);
        chk("loop_errs",  {ef_a, ep_a, eo_a}, 3'b000);
        pop_chk(0, 8'h00, "loop0");
        pop_chk(0, 8'hFF, "loop1");
        pop_chk(0, 8'h3C, "loop2");
        @(negedge clk);
        chk("loop_empty", sa.rx_valid, 0);
        repeat (20) @(posedge clk);
        loop_a = 1'b0;

        // Overrun: five frames into a depth-4 FIFO that is never popped
        div_a = 16'd8;
        repeat (4) @(posedge clk);
        for (int f = 1; f <= 5; f++)
            drive(0, {2'b00, 1'b1, 8'(f * 17), 1'b0}, 10, 8);
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("ovr_level",   rxl_a, 4);
        chk("ovr_flag",    eo_a, 1);
        chk("ovr_noframe", ef_a, 0);
        pop_chk(0, 8'h11, "ovr0");
        pop_chk(0, 8'h22, "ovr1");
        pop_chk(0, 8'h33, "ovr2");
        pop_chk(0, 8'h44, "ovr3");
        clear_a();
        @(negedge clk);
        chk("ovr_cleared", eo_a, 0);
        chk("ovr_drained", rxl_a, 0);

        // Framing error: stop bit low
        drive(0, {2'b00, 1'b0, 8'h55, 1'b0}, 10, 8);
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("frm_flag",  ef_a, 1);
        chk("frm_level", rxl_a, 0);
        clear_a();
        @(negedge clk);
        chk("frm_cleared", ef_a, 0);

        // Two-cycle glitch at divisor 16, then a good frame
        div_a = 16'd16;
        @(posedge clk); #1;
        rxd_drv_a = 1'b0;
        repeat (2) @(posedge clk);
        #1 rxd_drv_a = 1'b1;
        repeat (40) @(posedge clk);
        @(negedge clk);
        chk("glitch_level", rxl_a, 0);
        chk("glitch_errs",  {ef_a, ep_a, eo_a}, 3'b000);
        drive(0, {2'b00, 1'b1, 8'h5A, 1'b0}, 10, 16);
        repeat (4) @(posedge clk);
        pop_chk(0, 8'h5A, "after_glitch");

        // Odd parity: TX 0x03 carries parity 1; RX with wrong parity is dropped
        push(1, 8'h03);
        check_tx(1, {1'b0, 1'b1, 1'b1, 8'h03, 1'b0}, 11, 8, "txpar", obs);
        chk("par_bit", obs[9], 1);
        drive(1, {1'b0, 1'b1, 1'b0, 8'h03, 1'b0}, 11, 8);
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("par_err",   ep_b, 1);
        chk("par_level", rxl_b, 0);
        chk("par_noframe", ef_b, 0);
        drive(1, {1'b0, 1'b1, 1'b1, 8'h81, 1'b0}, 11, 8);
        repeat (4) @(posedge clk);
        pop_chk(1, 8'h81, "par_good");

        // Reset in the middle of a TX frame with three bytes queued
        div_a = 16'd8;
        push(0, 8'h12);
        push(0, 8'h34);
        push(0, 8'h56);
        push(0, 8'h78);
        repeat (30) @(posedge clk);
        @(negedge clk);
        chk("mid_level", txl_a, 3);
        chk("mid_busy",  busy_a, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_txd",   txd_a, 1);
        chk("rst_mid_level", txl_a, 0);
        chk("rst_mid_busy",  busy_a, 0);
        chk("rst_mid_ready", sa.tx_ready, 1);
        lows = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (txd_a !== 1'b1) lows++;
        end
        chk("rst_mid_quiet", lows, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
